ternary_matvec: RTL and testbench

- Ternary matrix-vector multiply stage: y = W·x, with W a D×D ternary matrix and x a D-element fixed-point vector.
- Sits directly downstream of the RMS-norm stage; consumes its vector_t output and produces a vector_t for the next layer.
- Column-serial: one column of W is applied per cycle across all D rows in parallel.
- valid/ready handshakes on input and output.

---
 rtl/ternary_matvec_pkg.sv | 29 ++
 rtl/ternary_mac_lane.sv | 37 +++
 rtl/ternary_matvec.sv | 86 ++++++++
 tb/tb_ternary_matvec.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_matvec_pkg.sv
// Shared types and helpers for the ternary matrix-vector stage.
// Fixed-point elements, ternary weights and the saturating accumulator narrowing.
package ternary_matvec_pkg;

  localparam int D                   = 4;
  localparam int FixedPointPrecision = 8;
  localparam int FixedPointMax       = 127;
  localparam int FixedPointMin       = -128;
  localparam int MatvecAccWidth      = FixedPointPrecision + $clog2(D) + 1;
  localparam int ColWidth            = (D > 1) ? $clog2(D) : 1;

  typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]                  vector_t;
  typedef logic signed [1:0]                     ternary_t;
  typedef ternary_t [D-1:0][D-1:0]               ternary_matrix_t;
  typedef logic signed [MatvecAccWidth-1:0]      acc_t;
  typedef logic [ColWidth-1:0]                   col_t;

  localparam ternary_t TernaryPos  = 2'sb01;
  localparam ternary_t TernaryNeg  = 2'sb11;
  localparam ternary_t TernaryZero = 2'sb00;

  function automatic fixed_point_t sat_to_fixed(acc_t a);
    if (a > acc_t'(FixedPointMax)) return fixed_point_t'(FixedPointMax);
    if (a < acc_t'(FixedPointMin)) return fixed_point_t'(FixedPointMin);
    return fixed_point_t'(a);
  endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One row accumulator: adds +x, -x or nothing per cycle depending on the ternary weight.
// acc presents the running sum including the current cycle's term.
module ternary_mac_lane
  import ternary_matvec_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear,
  input  logic         en,
  input  ternary_t     weight,
  input  fixed_point_t x,
  output acc_t         acc
);

  acc_t acc_q;
  acc_t term;

  always_comb begin
    // NOTE: term gets a default before the case so no path leaves it unassigned (no latch).
    term = '0;
    case (weight)
      TernaryPos: term = acc_t'(x);
      TernaryNeg: term = -acc_t'(x);
      default:    term = '0;  // zero and the illegal 2'b10 code
    endcase
  end

  assign acc = en ? acc_q + term : acc_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)    acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en)    acc_q <= acc;
  end

endmodule

// File: rtl/ternary_matvec.sv
// Column-serial ternary matrix-vector multiply y = W*x with valid/ready on both sides.
// One column of W is applied per cycle to all rows; the result saturates to fixed point.
module ternary_matvec
  import ternary_matvec_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  vector_t         x_i,
  input  ternary_matrix_t w_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output vector_t         y_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]      state_q;
  col_t            col_q;
  vector_t         x_q;
  ternary_matrix_t w_q;
  vector_t         y_q;
  acc_t            lane_acc [D];

  logic accept;
  logic last_col;

  assign accept   = (state_q == IDLE) && in_valid_i;
  assign last_col = (col_q == col_t'(D - 1));

  for (genvar i = 0; i < D; i++) begin : g_lane
    ternary_mac_lane u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (accept),
      .en     (state_q == COMPUTE),
      .weight (w_q[i][col_q]),
      .x      (x_q[col_q]),
      .acc    (lane_acc[i])
    );
  end

  // NOTE: operand registers are not reset; they are always loaded on accept before being read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_q <= x_i;
      w_q <= w_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            col_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          col_q <= col_q + col_t'(1);
          if (last_col) begin
            for (int i = 0; i < D; i++) y_q[i] <= sat_to_fixed(lane_acc[i]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign y_o         = y_q;

endmodule

// File: tb/tb_ternary_matvec.sv
// Directed bench for ternary_matvec: hand-computed results, latency, back-pressure,
// mid-operation reset and back-to-back throughput.
module tb_ternary_matvec;
  import ternary_matvec_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  vector_t         x_i;
  ternary_matrix_t w_i;
  logic            out_valid_o;
  logic            out_ready_i;
  vector_t         y_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ternary_matvec dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .w_i         (w_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .y_o         (y_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vector_t mk_vec(int a, int b, int c, int d);
    vector_t v;
    v[0] = fixed_point_t'(a);
    v[1] = fixed_point_t'(b);
    v[2] = fixed_point_t'(c);
    v[3] = fixed_point_t'(d);
    return v;
  endfunction

  function automatic ternary_matrix_t mk_identity();
    ternary_matrix_t m;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        m[i][j] = (i == j) ? TernaryPos : TernaryZero;
    return m;
  endfunction

  function automatic ternary_matrix_t mk_fill(ternary_t t);
    ternary_matrix_t m;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        m[i][j] = t;
    return m;
  endfunction

  // Accepts one operand pair, scrambles the inputs afterwards, checks latency and result.
  task automatic run_op(string name, vector_t x, ternary_matrix_t w, vector_t exp);
    int n;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: in_ready_o=%b required 1", name, in_ready_o);
    end
    in_valid_i = 1'b1;
    x_i        = x;
    w_i        = w;
    step();
    in_valid_i = 1'b0;
    x_i        = ~x;
    w_i        = ~w;
    n = 0;
    while (out_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles required 4", name, n);
    end
    total++;
    if (y_o !== exp) begin
      bad++;
      $display("FAIL %s_y: got %h required %h", name, y_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    x_i         = '0;
    w_i         = '0;
    step();
    step();
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || y_o !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%h required 1 0 0",
               in_ready_o, out_valid_o, y_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_identity();
    run_op("identity", mk_vec(8, 16, -24, 4), mk_identity(), mk_vec(8, 16, -24, 4));
  endtask

  task automatic test_saturation();
    run_op("sat_pos", mk_vec(127, 127, 127, 127), mk_fill(TernaryPos),
           mk_vec(127, 127, 127, 127));
    run_op("sat_neg", mk_vec(127, 127, 127, 127), mk_fill(TernaryNeg),
           mk_vec(-128, -128, -128, -128));
    run_op("sat_negneg", mk_vec(-128, -128, -128, -128), mk_fill(TernaryNeg),
           mk_vec(127, 127, 127, 127));
  endtask

  task automatic test_mixed();
    ternary_matrix_t w;
    w = '0;
    w[0][0] = TernaryPos; w[0][1] = TernaryNeg; w[0][2] = TernaryZero; w[0][3] = TernaryPos;
    w[1][0] = TernaryPos; w[1][1] = TernaryZero; w[1][2] = 2'b10;      w[1][3] = TernaryZero;
    w[2][0] = TernaryZero; w[2][1] = TernaryZero; w[2][2] = TernaryPos; w[2][3] = TernaryZero;
    w[3][0] = TernaryNeg; w[3][1] = TernaryNeg; w[3][2] = TernaryNeg; w[3][3] = TernaryNeg;
    // row0: 10-3-5=2, row1: 10 (illegal code ignored), row2: 50, row3: -10-3-50+5=-58
    run_op("mixed", mk_vec(10, 3, 50, -5), w, mk_vec(2, 10, 50, -58));
  endtask

  task automatic test_backpressure();
    vector_t exp_a;
    vector_t exp_b;
    exp_a       = mk_vec(1, 2, 3, 4);
    exp_b       = mk_vec(-7, 9, -11, 13);
    step();
    out_ready_i = 1'b0;
    run_op("bp_first", exp_a, mk_identity(), exp_a);
    for (int k = 0; k < 6; k++) begin
      in_valid_i = 1'b1;
      x_i        = exp_b;
      w_i        = mk_identity();
      step();
      total++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || y_o !== exp_a) begin
        bad++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b y=%h required 1 0 %h",
                 k, out_valid_o, in_ready_o, y_o, exp_a);
      end
    end
    out_ready_i = 1'b1;
    step();
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0",
               in_ready_o, out_valid_o);
    end
    run_op("bp_next", exp_b, mk_identity(), exp_b);
  endtask

  task automatic test_reset_mid();
    step();
    in_valid_i = 1'b1;
    x_i        = mk_vec(5, 6, 7, 8);
    w_i        = mk_identity();
    step();
    in_valid_i = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || y_o !== '0) begin
      bad++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b y=%h required 1 0 0",
               in_ready_o, out_valid_o, y_o);
    end
    run_op("after_reset", mk_vec(8, 16, -24, 4), mk_identity(), mk_vec(8, 16, -24, 4));
  endtask

  task automatic test_back_to_back();
    int n_valid;
    n_valid     = 0;
    out_ready_i = 1'b1;
    step();
    for (int c = 0; c < 18; c++) begin
      in_valid_i = 1'b1;
      x_i        = mk_vec(4 * c + 1, 4 * c + 2, 4 * c + 3, -(4 * c + 4));
      w_i        = mk_identity();
      step();
      total++;
      if (out_valid_o !== ((c % 6) == 4)) begin
        bad++;
        $display("FAIL b2b_valid_c%0d: out_valid=%b required %b", c, out_valid_o, (c % 6) == 4);
      end
      if ((c % 6) == 4) begin
        n_valid++;
        total++;
        if (y_o !== mk_vec(4 * (c - 4) + 1, 4 * (c - 4) + 2, 4 * (c - 4) + 3, -(4 * (c - 4) + 4))) begin
          bad++;
          $display("FAIL b2b_y_c%0d: got %h required %h", c, y_o,
                   mk_vec(4 * (c - 4) + 1, 4 * (c - 4) + 2, 4 * (c - 4) + 3, -(4 * (c - 4) + 4)));
        end
      end
    end
    in_valid_i = 1'b0;
    total++;
    if (n_valid !== 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d results required 3", n_valid);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
